// File: rtl/acc_alu_nb.sv
// -----------------------------------------------------------------------------
// acc_alu_nb -- WIDTH-bit accumulator ALU for the multi-cycle CPU datapath.
//
// Single-cycle ops (NOP/LOAD/ADD/SUB/AND/OR/SHL1) update the accumulator at
// the falling clock edge where they are issued. MUL is an iterative shift-add
// multiply that takes WIDTH edges, raises busy while it runs, and pulses done
// for one period when the product is written back.
//
// Optional feature macro: ACC_SAT_EN
//   defined   -> ADD/SUB saturate to the signed limit on signed overflow.
//   undefined -> ADD/SUB wrap modulo 2^WIDTH.
//
// Ports:
//   clk    in   system clock; all state changes on the falling edge
//   rst    in   synchronous active-high reset, sampled on the falling edge
//   in     in   [WIDTH-1:0] operand
//   op     in   [2:0] operation select
//   op_en  in   execute op this edge (ignored while busy)
//   out    out  [WIDTH-1:0] accumulator contents
//   busy   out  multiply in progress
//   done   out  one-period pulse after the MUL result is written
//   zero   out  accumulator == 0 (combinational)
//   carry  out  registered carry / borrow / shifted-out bit
//   ovf    out  registered signed overflow
// -----------------------------------------------------------------------------
module acc_alu_nb #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic             op_en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_SHL1 = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic             carry_q,  carry_d;
  logic             ovf_q,    ovf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q,   prod_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  op_e              op_sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] prod_step;

  assign op_sel = op_e'(op);

  // One extra MSB captures carry-out on ADD and borrow on SUB.
  assign sum  = {1'b0, acc_q} + {1'b0, in};
  assign diff = {1'b0, acc_q} - {1'b0, in};

  // ADD overflows when both operands share a sign the result lacks; SUB
  // overflows when the operands differ in sign and the result leaves acc's.
  assign add_ovf = (acc_q[WIDTH-1] == in[WIDTH-1]) && (sum[WIDTH-1]  != acc_q[WIDTH-1]);
  assign sub_ovf = (acc_q[WIDTH-1] != in[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);

`ifdef ACC_SAT_EN
  // On overflow the true result lies on acc's side of zero in both cases,
  // so acc's sign picks the limit to clamp to.
  assign add_res = add_ovf ? (acc_q[WIDTH-1] ? SAT_NEG : SAT_POS) : sum[WIDTH-1:0];
  assign sub_res = sub_ovf ? (acc_q[WIDTH-1] ? SAT_NEG : SAT_POS) : diff[WIDTH-1:0];
`else
  assign add_res = sum[WIDTH-1:0];
  assign sub_res = diff[WIDTH-1:0];
`endif

  // Partial product including this edge's conditional addition.
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statements leaves it unassigned (which would infer a latch).
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (op_en) begin
          unique case (op_sel)
            OP_NOP: ;
            OP_LOAD: begin
              acc_d   = in;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
            end
            OP_ADD: begin
              acc_d   = add_res;
              carry_d = sum[WIDTH];
              ovf_d   = add_ovf;
            end
            OP_SUB: begin
              acc_d   = sub_res;
              carry_d = diff[WIDTH];
              ovf_d   = sub_ovf;
            end
            OP_AND: begin
              acc_d   = acc_q & in;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
            end
            OP_OR: begin
              acc_d   = acc_q | in;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
            end
            OP_SHL1: begin
              acc_d   = {acc_q[WIDTH-2:0], 1'b0};
              carry_d = acc_q[WIDTH-1];
              ovf_d   = 1'b0;
            end
            OP_MUL: begin
              mcand_d  = acc_q;
              mplier_d = in;
              prod_d   = '0;
              cnt_d    = CNT_W'(WIDTH);
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // Last iteration: commit the product including this edge's addition.
        if (cnt_q == CNT_W'(1)) begin
          acc_d   = prod_step;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over everything, so a MUL in flight is dropped without done.
  always_ff @(negedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q  <= S_IDLE;
      acc_q    <= RST_VAL;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out   = acc_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zero  = (acc_q == '0);

endmodule

// File: tb/tb_acc_alu_nb.sv
// -----------------------------------------------------------------------------
// tb_acc_alu_nb -- directed self-checking bench for acc_alu_nb (WIDTH=16).
// Expected results go into a scoreboard queue when stimulus is driven and are
// popped and compared once the DUT has produced the matching output. Inputs
// change on the rising edge; outputs are sampled on the rising edge, half a
// period after the falling edge at which the DUT updates.
// Build with ACC_SAT_EN defined to check the saturating variant.
// -----------------------------------------------------------------------------
module tb_acc_alu_nb;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef struct {
    string       tag;
    logic [15:0] out;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] in_v;
  logic [2:0]  op_v;
  logic        en_v;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        zero;
  logic        carry;
  logic        ovf;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  acc_alu_nb #(
    .WIDTH   (16),
    .RST_VAL (16'h0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .op    (op_v),
    .op_en (en_v),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .zero  (zero),
    .carry (carry),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance across one active (falling) edge and return at the next rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [15:0] o, input logic c,
                          input logic v, input logic b, input logic d);
    exp_t e;
    e.tag   = tag;
    e.out   = o;
    e.zero  = (o == 16'h0000);
    e.carry = c;
    e.ovf   = v;
    e.busy  = b;
    e.done  = d;
    exp_q.push_back(e);
  endtask

  task automatic compare_next();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".out"},   {16'h0, out}, {16'h0, e.out});
    check({e.tag, ".zero"},  {31'h0, zero},  {31'h0, e.zero});
    check({e.tag, ".carry"}, {31'h0, carry}, {31'h0, e.carry});
    check({e.tag, ".ovf"},   {31'h0, ovf},   {31'h0, e.ovf});
    check({e.tag, ".busy"},  {31'h0, busy},  {31'h0, e.busy});
    check({e.tag, ".done"},  {31'h0, done},  {31'h0, e.done});
  endtask

  // One single-cycle operation: drive, record expectation, clock, compare.
  task automatic step(input string tag, input logic [2:0] o, input logic [15:0] i,
                      input logic en, input logic [15:0] e_out, input logic e_c,
                      input logic e_v);
    op_v = o;
    in_v = i;
    en_v = en;
    push_exp(tag, e_out, e_c, e_v, 1'b0, 1'b0);
    tick();
    compare_next();
  endtask

  // Issue MUL against the current accumulator `held`, then wait (bounded) for
  // done. Optionally issue an ADD while busy that must be ignored.
  task automatic mul_run(input string tag, input logic [15:0] i, input logic [15:0] held,
                         input logic [15:0] e_res, input bit inject);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    op_v = OP_MUL;
    in_v = i;
    en_v = 1'b1;
    push_exp(tag, e_res, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check({tag, ".accept_busy"}, {31'h0, busy}, 32'd1);
    check({tag, ".accept_out"},  {16'h0, out},  {16'h0, held});
    check({tag, ".accept_done"}, {31'h0, done}, 32'd0);
    en_v = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (inject && e == 5) begin
        op_v = OP_ADD;
        in_v = 16'h1111;
        en_v = 1'b1;
      end
      if (inject && e == 7) en_v = 1'b0;
      tick();
      edges = e;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check({tag, ".busy_mid"}, {31'h0, busy}, 32'd1);
      check({tag, ".out_held"}, {16'h0, out},  {16'h0, held});
    end
    en_v = 1'b0;
    if (seen) begin
      check({tag, ".latency"}, edges, 32'd16);
      compare_next();
    end else begin
      check({tag, ".done_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int done_pulses;
    rst  = 1'b1;
    en_v = 1'b0;
    op_v = OP_NOP;
    in_v = 16'h0;
    @(posedge clk);
    tick();
    push_exp("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    compare_next();
    rst = 1'b0;

    // Signed overflow on ADD and SUB.
    step("load_7fff", OP_LOAD, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 1'b0);
`ifdef ACC_SAT_EN
    step("add_ovf",   OP_ADD,  16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
`else
    step("add_ovf",   OP_ADD,  16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1);
`endif
    step("load_8000", OP_LOAD, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0);
`ifdef ACC_SAT_EN
    step("sub_ovf",   OP_SUB,  16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1);
`else
    step("sub_ovf",   OP_SUB,  16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
`endif

    // Borrow and zero.
    step("load_0",     OP_LOAD, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    step("sub_borrow", OP_SUB,  16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step("sub_to_0",   OP_SUB,  16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Shift, hold with op_en low, NOP.
    step("load_8001", OP_LOAD, 16'h8001, 1'b1, 16'h8001, 1'b0, 1'b0);
    step("shl1",      OP_SHL1, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b0);
    step("hold_en0",  OP_LOAD, 16'h1234, 1'b0, 16'h0002, 1'b1, 1'b0);
    step("nop",       OP_NOP,  16'hFFFF, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Logic ops.
    step("load_f0f0", OP_LOAD, 16'hF0F0, 1'b1, 16'hF0F0, 1'b0, 1'b0);
    step("and",       OP_AND,  16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0);
    step("or",        OP_OR,   16'h0F0F, 1'b1, 16'h3F3F, 1'b0, 1'b0);

    // Multiply with an ignored mid-flight ADD, then done clears.
    step("load_0012", OP_LOAD, 16'h0012, 1'b1, 16'h0012, 1'b0, 1'b0);
    mul_run("mul_12x34", 16'h0034, 16'h0012, 16'h03A8, 1'b1);
    step("done_clear", OP_NOP, 16'h0000, 1'b0, 16'h03A8, 1'b0, 1'b0);

    // Full-width multiply; a LOAD issued in the done cycle is accepted.
    step("load_ffff", OP_LOAD, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    mul_run("mul_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
    step("load_in_done", OP_LOAD, 16'h00AB, 1'b1, 16'h00AB, 1'b0, 1'b0);

    // Reset on the 5th MUL edge aborts the multiply with no done pulse.
    step("load_0003", OP_LOAD, 16'h0003, 1'b1, 16'h0003, 1'b0, 1'b0);
    op_v = OP_MUL;
    in_v = 16'h0005;
    en_v = 1'b1;
    tick();
    check("rstmul.accept_busy", {31'h0, busy}, 32'd1);
    en_v = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    push_exp("rst_mid_mul", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    compare_next();
    rst = 1'b0;
    step("load_after_rst", OP_LOAD, 16'h0005, 1'b1, 16'h0005, 1'b0, 1'b0);
    done_pulses = 0;
    en_v = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) done_pulses++;
    end
    check("rst_no_done", done_pulses, 32'd0);
    check("rst_out_kept", {16'h0, out}, 32'h0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
